vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator with an aligned pixel-data path; the next generation of the board's fixed 640x480 VGA output stage. Produces horizontal/vertical sync, blanking, and pixel coordinates for any mode, with configurable sync polarity and a pixel clock-enable. Coordinates go to the upstream pixel source (game board renderer). Returned colour is registered and aligned with delayed sync/blank before driving the DAC pins.

---
 rtl/vga_timing_pkg.sv | 49 ++++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 188 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and helpers for the VGA raster timing generator.
//   - DEF_*      : 640x480@60 default timing (25.175 MHz nominal pixel rate)
//   - BAR_*      : colour-bar channel masks {R,G,B}; a set bit is full scale
//   - calc_total : total pixels/lines of one axis from its four regions
//   - bar_rgb    : channel mask of colour bar 0..7
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef logic [2:0] bar_rgb_t;

    localparam bar_rgb_t BAR_WHITE   = 3'b111;
    localparam bar_rgb_t BAR_YELLOW  = 3'b110;
    localparam bar_rgb_t BAR_CYAN    = 3'b011;
    localparam bar_rgb_t BAR_GREEN   = 3'b010;
    localparam bar_rgb_t BAR_MAGENTA = 3'b101;
    localparam bar_rgb_t BAR_RED     = 3'b100;
    localparam bar_rgb_t BAR_BLUE    = 3'b001;
    localparam bar_rgb_t BAR_BLACK   = 3'b000;

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic bar_rgb_t bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Enabled shift register of depth D; each stage advances only when en is high.
// Ports:
//   VGA_CLK  in   clock
//   reset    in   synchronous active-low reset, clears every stage to 0
//   en       in   shift enable (pixel tick)
//   d        in   W-bit input word
//   q        out  d delayed by D enabled ticks
// -----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         VGA_CLK,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [D];

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) sr[i] <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[D-1];

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator with an aligned pixel-data path.
// Optional feature macro: VGA_TESTPATTERN_EN (adds test_mode and an 8-bar
// colour generator that replaces rgb_* while test_mode is high).
// Ports:
//   VGA_CLK            in   clock
//   reset              in   synchronous active-low reset
//   pix_en             in   pixel tick; all state advances only when high
//   test_mode          in   (VGA_TESTPATTERN_EN only) select colour bars
//   pix_x, pix_y       out  current coordinate (valid when pix_active)
//   pix_active         out  current coordinate is visible
//   frame_start        out  one-tick pulse at (0,0)
//   line_start         out  one-tick pulse at x = 0
//   rgb_r/g/b          in   pixel colour, PIX_LAT ticks after its coordinate
//   VGA_R/G/B          out  colour to DAC, zero outside the visible region
//   VGA_HS, VGA_VS     out  syncs, asserted level H_POL / V_POL
//   VGA_BLANK_N        out  high during visible region
// Sync, blank and colour lag the coordinates by PIX_LAT+1 ticks.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CNT_W    = 10,
    parameter int COLOR_W  = 8,
    parameter int PIX_LAT  = 1
) (
    input  logic               VGA_CLK,
    input  logic               reset,
    input  logic               pix_en,
`ifdef VGA_TESTPATTERN_EN
    input  logic               test_mode,
`endif
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               pix_active,
    output logic               frame_start,
    output logic               line_start,
    input  logic [COLOR_W-1:0] rgb_r,
    input  logic [COLOR_W-1:0] rgb_g,
    input  logic [COLOR_W-1:0] rgb_b,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N
);

    localparam int H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // ---- p0: decode of the counter registers ----
    // Comparisons are done in int so a sync region ending exactly at
    // 2^CNT_W does not overflow the boundary constant.
    logic hs_p0, vs_p0, vld_p0;

    assign hs_p0  = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
    assign vs_p0  = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
    assign vld_p0 = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);

    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign pix_active  = vld_p0;
    assign line_start  = reset && pix_en && (h_cnt == '0);
    assign frame_start = line_start && (v_cnt == '0);

    // ---- p1: control delayed by PIX_LAT, aligned with rgb_* ----
    logic hs_p1, vs_p1, vld_p1;

    vga_delay_line #(.W(3), .D(PIX_LAT)) u_ctl_dly (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .en      (pix_en),
        .d       ({vld_p0, vs_p0, hs_p0}),
        .q       ({vld_p1, vs_p1, hs_p1})
    );

    logic [COLOR_W-1:0] src_r, src_g, src_b;

`ifdef VGA_TESTPATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx_p0;
    bar_rgb_t   bar_p1;

    // Smallest bar whose right edge lies beyond h_cnt; blanking columns
    // fall through to bar 7 and are masked by blank anyway.
    always_comb begin
        bar_idx_p0 = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (int'(h_cnt) < (i + 1) * BAR_W) bar_idx_p0 = 3'(i);
        end
    end

    vga_delay_line #(.W(3), .D(PIX_LAT)) u_bar_dly (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .en      (pix_en),
        .d       (bar_rgb(bar_idx_p0)),
        .q       (bar_p1)
    );

    always_comb begin
        src_r = rgb_r;
        src_g = rgb_g;
        src_b = rgb_b;
        if (test_mode) begin
            src_r = {COLOR_W{bar_p1[2]}};
            src_g = {COLOR_W{bar_p1[1]}};
            src_b = {COLOR_W{bar_p1[0]}};
        end
    end
`else
    assign src_r = rgb_r;
    assign src_g = rgb_g;
    assign src_b = rgb_b;
`endif

    // ---- p2: output register driving the DAC pins ----
    logic               hs_p2, vs_p2, vld_p2;
    logic [COLOR_W-1:0] r_p2, g_p2, b_p2;

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
            vld_p2 <= 1'b0;
            r_p2   <= '0;
            g_p2   <= '0;
            b_p2   <= '0;
        end else if (pix_en) begin
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            vld_p2 <= vld_p1;
            r_p2   <= vld_p1 ? src_r : '0;
            g_p2   <= vld_p1 ? src_g : '0;
            b_p2   <= vld_p1 ? src_b : '0;
        end
    end

    assign VGA_HS      = H_POL ? hs_p2 : ~hs_p2;
    assign VGA_VS      = V_POL ? vs_p2 : ~vs_p2;
    assign VGA_BLANK_N = vld_p2;
    assign VGA_R       = r_p2;
    assign VGA_G       = g_p2;
    assign VGA_B       = b_p2;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 12;
    localparam int H_BP     = 0;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam bit H_POL    = 1'b1;
    localparam bit V_POL    = 1'b0;
    localparam int CNT_W    = 5;
    localparam int COLOR_W  = 8;
    localparam int PIX_LAT  = 3;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 32 = 2^CNT_W
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 10
    localparam int LAG   = PIX_LAT + 1;

    logic               VGA_CLK = 1'b0;
    logic               reset;
    logic               pix_en;
`ifdef VGA_TESTPATTERN_EN
    logic               test_mode;
`endif
    logic [CNT_W-1:0]   pix_x, pix_y;
    logic               pix_active, frame_start, line_start;
    logic [COLOR_W-1:0] rgb_r, rgb_g, rgb_b;
    logic [COLOR_W-1:0] VGA_R, VGA_G, VGA_B;
    logic               VGA_HS, VGA_VS, VGA_BLANK_N;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .H_POL (H_POL), .V_POL (V_POL), .CNT_W (CNT_W),
        .COLOR_W (COLOR_W), .PIX_LAT (PIX_LAT)
    ) dut (
        .VGA_CLK     (VGA_CLK),
        .reset       (reset),
        .pix_en      (pix_en),
`ifdef VGA_TESTPATTERN_EN
        .test_mode   (test_mode),
`endif
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_active  (pix_active),
        .frame_start (frame_start),
        .line_start  (line_start),
        .rgb_r       (rgb_r),
        .rgb_g       (rgb_g),
        .rgb_b       (rgb_b),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: k = pixel ticks since reset release; everything
    // else is arithmetic on k.
    int          k       = 0;
    logic [23:0] exp_rgb = '0;
    logic [23:0] col [1024];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t k=%0d)", tag, got, exp, $time, k);
        end
    endtask

    function automatic int px(input int n);
        return n % H_TOT;
    endfunction

    function automatic int py(input int n);
        return (n / H_TOT) % V_TOT;
    endfunction

    function automatic bit visible(input int n);
        return (px(n) < H_ACTIVE) && (py(n) < V_ACTIVE);
    endfunction

    function automatic bit in_hs(input int n);
        return (px(n) >= H_ACTIVE + H_FP) && (px(n) < H_ACTIVE + H_FP + H_SYNC);
    endfunction

    function automatic bit in_vs(input int n);
        return (py(n) >= V_ACTIVE + V_FP) && (py(n) < V_ACTIVE + V_FP + V_SYNC);
    endfunction

    function automatic logic [23:0] bar_colour(input int x);
        case (x / (H_ACTIVE / 8))
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // One VGA_CLK cycle: drive at negedge, check 1 time unit later,
    // then advance the model on the posedge.
    task automatic cycle(input bit en, input bit rst_n, input bit tm, input bit do_chk);
        logic [23:0] drv;
        bit          ehs, evs, eblank;
        @(negedge VGA_CLK);
        reset  = rst_n;
        pix_en = en;
`ifdef VGA_TESTPATTERN_EN
        test_mode = tm;
`endif
        drv = (k >= PIX_LAT) ? col[(k - PIX_LAT) % 1024] : 24'($urandom);
        {rgb_r, rgb_g, rgb_b} = drv;
        #1;
        if (do_chk) begin
            ehs    = (k >= LAG) ? (in_hs(k - LAG) ? H_POL : !H_POL) : !H_POL;
            evs    = (k >= LAG) ? (in_vs(k - LAG) ? V_POL : !V_POL) : !V_POL;
            eblank = (k >= LAG) && visible(k - LAG);
            chk("pix_x",       int'(pix_x),       px(k));
            chk("pix_y",       int'(pix_y),       py(k));
            chk("pix_active",  int'(pix_active),  int'(visible(k)));
            chk("line_start",  int'(line_start),  int'(rst_n && en && px(k) == 0));
            chk("frame_start", int'(frame_start), int'(rst_n && en && px(k) == 0 && py(k) == 0));
            chk("VGA_HS",      int'(VGA_HS),      int'(ehs));
            chk("VGA_VS",      int'(VGA_VS),      int'(evs));
            chk("VGA_BLANK_N", int'(VGA_BLANK_N), int'(eblank));
            chk("VGA_RGB",     int'({VGA_R, VGA_G, VGA_B}), int'(exp_rgb));
        end
        @(posedge VGA_CLK);
        if (!rst_n) begin
            k       = 0;
            exp_rgb = '0;
        end else if (en) begin
            if (k >= PIX_LAT && visible(k - PIX_LAT))
                exp_rgb = (tm && TP_EN) ? bar_colour(px(k - PIX_LAT)) : col[(k - PIX_LAT) % 1024];
            else
                exp_rgb = '0;
            k++;
        end
    endtask

`ifdef VGA_TESTPATTERN_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif

    initial begin
        int n_rst;
        for (int i = 0; i < 1024; i++) col[i] = 24'($urandom);
        reset  = 1'b0;
        pix_en = 1'b0;
        {rgb_r, rgb_g, rgb_b} = '0;
`ifdef VGA_TESTPATTERN_EN
        test_mode = 1'b0;
`endif
        // Settle out of time-zero X, then check reset state (pix_en both ways).
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);

        // Continuous pixel ticks, two frames.
        for (int i = 0; i < 2 * H_TOT * V_TOT; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);

        // Half-rate pixel clock-enable.
        for (int i = 0; i < 2 * H_TOT * V_TOT; i++) cycle(i[0] == 1'b0, 1'b1, 1'b0, 1'b1);

        // Random gaps, then a mid-frame reset at a random point.
        for (int i = 0; i < 300 + int'($urandom_range(0, 200)); i++)
            cycle(($urandom % 4) != 0, 1'b1, 1'b0, 1'b1);
        n_rst = int'($urandom_range(1, 3));
        for (int i = 0; i < n_rst; i++) cycle(1'($urandom), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 500; i++) cycle(($urandom % 4) != 0, 1'b1, 1'b0, 1'b1);

        // Reset while in the sync / blanking area of the frame.
        while (!(py(k) == V_ACTIVE + V_FP && px(k) == H_ACTIVE + H_FP + 2))
            cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < H_TOT * V_TOT; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);

        // Test mode (colour bars when the feature is built in), random gaps.
        for (int i = 0; i < 2 * H_TOT * V_TOT; i++) cycle(($urandom % 3) != 0, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
